// File: rtl/gamma_sequencer.sv
// gamma_sequencer: gamma-cycle controller that frames grst, turns queued spike
// times into fixed-width input pulses and timestamps the first rise of q.
module gamma_sequencer #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH = 8,
   parameter int N_IN = 2,
   parameter int TW = 4
) (
   input  logic aclk,
   input  logic rst,
   input  logic en,
   input  logic op_valid,
   output logic op_ready,
   input  logic [N_IN-1:0] op_spike,
   input  logic [N_IN*TW-1:0] op_time,
   output logic grst,
   output logic [N_IN-1:0] pulse_out,
   input  logic q,
   output logic gamma_start,
   output logic res_valid,
   output logic res_none,
   output logic [TW-1:0] res_time
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d, win_t, nxt_t, rt_q, rt_d, res_time_q;
   logic cap_q, cap_d, last, wrap, xfer, hit;
   logic pend_full_q, pend_full_d, op_ready_q, grst_q, gamma_start_q, res_valid_q, res_none_q;
   logic [N_IN-1:0] pend_spk_q, pend_spk_d, act_spk_q, act_spk_d, pulse_q, pulse_d;
   logic [N_IN*TW-1:0] pend_tm_q, pend_tm_d, act_tm_q, act_tm_d;

   assign last = state_q == RUN && cnt_q == TW'(GAMMA_CYCLE_WIDTH - 1);
   assign wrap = state_q == IDLE || last;
   assign xfer = op_valid && op_ready_q;
   assign win_t = cnt_q - TW'(1);
   assign hit = state_q == RUN && cnt_q != '0 && q && !cap_q;

   always_comb begin
      state_d = wrap ? (en ? RUN : IDLE) : state_q;
      cnt_d = wrap ? '0 : cnt_q + TW'(1);
      nxt_t = cnt_d - TW'(1);
      cap_d = cap_q | hit;
      rt_d = hit ? win_t : rt_q;
      pend_full_d = !last && (pend_full_q || xfer);
      pend_spk_d = (xfer && !last) ? op_spike : pend_spk_q;
      pend_tm_d = (xfer && !last) ? op_time : pend_tm_q;
      // an empty slot at the boundary lets a same-cycle transfer skip the pending stage
      act_spk_d = !last ? act_spk_q : pend_full_q ? pend_spk_q : xfer ? op_spike : '0;
      act_tm_d = !last ? act_tm_q : pend_full_q ? pend_tm_q : xfer ? op_time : '0;
      pulse_d = '0;
      for (int i = 0; i < N_IN; i++)
         pulse_d[i] = state_d == RUN && cnt_d != '0 && act_spk_q[i]
            && {1'b0, nxt_t} >= {1'b0, act_tm_q[i*TW +: TW]}
            && {1'b0, nxt_t} < {1'b0, act_tm_q[i*TW +: TW]} + (TW+1)'(PULSE_WIDTH);
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         cap_q <= 1'b0;
         rt_q <= '0;
         pend_full_q <= 1'b0;
         pend_spk_q <= '0;
         pend_tm_q <= '0;
         act_spk_q <= '0;
         act_tm_q <= '0;
         op_ready_q <= 1'b0;
         grst_q <= 1'b1;
         pulse_q <= '0;
         gamma_start_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_none_q <= 1'b0;
         res_time_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         cap_q <= cap_d && !last;
         rt_q <= last ? '0 : rt_d;
         pend_full_q <= pend_full_d;
         pend_spk_q <= pend_spk_d;
         pend_tm_q <= pend_tm_d;
         act_spk_q <= act_spk_d;
         act_tm_q <= act_tm_d;
         op_ready_q <= !pend_full_d;
         grst_q <= state_d == IDLE || cnt_d == '0;
         pulse_q <= pulse_d;
         gamma_start_q <= state_d == RUN && cnt_d == '0;
         res_valid_q <= last;
         if (last) begin
            res_none_q <= !cap_d;
            res_time_q <= cap_d ? rt_d : '0;
         end
      end
   end

   assign op_ready = op_ready_q;
   assign grst = grst_q;
   assign pulse_out = pulse_q;
   assign gamma_start = gamma_start_q;
   assign res_valid = res_valid_q;
   assign res_none = res_none_q;
   assign res_time = res_time_q;
endmodule

// File: tb/tb_gamma_sequencer.sv
// tb_gamma_sequencer: directed bench with a gamma-cycle level model and
// hand-computed pulse/result expectations for gamma_sequencer.
module tb_gamma_sequencer;
   localparam int G = 16;
   localparam int PW = 8;
   localparam int N = 2;
   localparam int TW = 4;

   typedef struct packed {
      logic [N-1:0] s;
      logic [N*TW-1:0] t;
   } op_t;

   logic aclk, rst, en, op_valid, op_ready, grst, q, gamma_start, res_valid, res_none;
   logic [N-1:0] op_spike, pulse_out;
   logic [N*TW-1:0] op_time;
   logic [TW-1:0] res_time;
   logic q_mode, q_force;

   int total = 0;
   int bad = 0;

   bit m_started = 0, m_in_rst = 0, m_running = 0;
   int m_cnt = 0, m_first = -1;
   op_t m_act, m_pq[$];
   logic e_grst, e_gs, e_rv, e_rn, e_ready;
   logic [N-1:0] e_pulse;
   logic [TW-1:0] e_rt;

   logic [TW:0] res_q[$];
   logic [2*G-1:0] snap_q[$];
   logic [G-1:0] h0, h1;

   gamma_sequencer #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .N_IN(N), .TW(TW)) dut (
      .aclk(aclk), .rst(rst), .en(en), .op_valid(op_valid), .op_ready(op_ready),
      .op_spike(op_spike), .op_time(op_time), .grst(grst), .pulse_out(pulse_out),
      .q(q), .gamma_start(gamma_start), .res_valid(res_valid), .res_none(res_none),
      .res_time(res_time)
   );

   assign q = q_mode ? |pulse_out : q_force;

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: gamma-cycle bookkeeping straight from the behavioural rules.
   always @(posedge aclk) begin
      bit last, xfer;
      int tt, w;
      m_started = 1;
      m_in_rst = rst;
      if (rst) begin
         m_running = 0;
         m_cnt = 0;
         m_first = -1;
         m_pq.delete();
         m_act = '0;
         e_grst = 1; e_gs = 0; e_rv = 0; e_rn = 0; e_rt = '0; e_ready = 0; e_pulse = '0;
      end else begin
         last = m_running && m_cnt == G - 1;
         xfer = op_valid && e_ready;
         if (m_running && m_cnt >= 1 && q && m_first < 0) m_first = m_cnt - 1;
         e_rv = last;
         if (last) begin
            e_rn = m_first < 0;
            e_rt = m_first < 0 ? '0 : TW'(m_first);
            m_first = -1;
            if (m_pq.size() > 0) m_act = m_pq.pop_front();
            else if (xfer) m_act = {op_spike, op_time};
            else m_act = '0;
         end else if (xfer) m_pq.push_back({op_spike, op_time});
         if (!m_running || last) begin
            m_running = en;
            m_cnt = 0;
         end else m_cnt++;
         e_grst = !m_running || m_cnt == 0;
         e_gs = m_running && m_cnt == 0;
         for (int i = 0; i < N; i++) begin
            tt = int'(m_act.t[i*TW +: TW]);
            w = m_cnt - 1;
            e_pulse[i] = m_running && m_cnt >= 1 && m_act.s[i] && w >= tt && w < tt + PW;
         end
         e_ready = m_pq.size() == 0;
      end
   end

   always @(negedge aclk) begin
      if (m_started) begin
         chk("grst", 32'(grst), 32'(e_grst));
         chk("pulse_out", 32'(pulse_out), 32'(e_pulse));
         chk("gamma_start", 32'(gamma_start), 32'(e_gs));
         chk("res_valid", 32'(res_valid), 32'(e_rv));
         chk("op_ready", 32'(op_ready), 32'(e_ready));
         if (e_rv || m_in_rst) begin
            chk("res_none", 32'(res_none), 32'(e_rn));
            chk("res_time", 32'(res_time), 32'(e_rt));
         end
      end
   end

   always @(negedge aclk) begin
      if (m_started && res_valid === 1'b1) res_q.push_back({res_none, res_time});
      if (m_running) begin
         h0[m_cnt] = pulse_out[0];
         h1[m_cnt] = pulse_out[1];
         if (m_cnt == G - 1) snap_q.push_back({h1, h0});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #2;
   endtask

   task automatic wait_cnt(input int c);
      int k = 0;
      do begin
         tick(1);
         k++;
      end while (!(m_running && m_cnt == c) && k < 40);
      chk("wait_cnt", 32'(m_running && m_cnt == c), 32'd1);
   endtask

   task automatic run_results(input int n);
      int k = 0;
      while (res_q.size() < n && k < 100) begin
         @(negedge aclk);
         #1;
         k++;
      end
      chk("res_timeout", 32'(res_q.size() >= n), 32'd1);
   endtask

   task automatic clear_logs();
      res_q.delete();
      snap_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1; en = 1; op_valid = 1; op_spike = 2'b11; op_time = {4'd5, 4'd3};
      q_mode = 0; q_force = 0;
      tick(3);
      chk("rst_grst", 32'(grst), 32'd1);
      chk("rst_ready", 32'(op_ready), 32'd0);
      chk("rst_pulse", 32'(pulse_out), 32'd0);
      chk("rst_gs", 32'(gamma_start), 32'd0);
      rst = 0; en = 0; op_valid = 0;
      tick(1);
      chk("idle_ready", 32'(op_ready), 32'd1);
      chk("idle_grst", 32'(grst), 32'd1);

      op_valid = 1; en = 1;
      tick(1);
      op_valid = 0; q_mode = 1;
      chk("run_gs", 32'(gamma_start), 32'd1);
      chk("run_grst", 32'(grst), 32'd1);
      chk("t2_pend", 32'(op_ready), 32'd0);
      clear_logs();
      run_results(2);
      chk("t2_res0", 32'(res_q[0]), 32'h10);
      chk("t2_res1", 32'(res_q[1]), 32'h03);
      chk("t2_snap0", 32'(snap_q[0]), 32'h0);
      chk("t2_pa", 32'(snap_q[1][G-1:0]), 32'h0FF0);
      chk("t2_pb", 32'(snap_q[1][2*G-1:G]), 32'h3FC0);

      clear_logs();
      run_results(1);
      chk("t3_none", 32'(res_q[0]), 32'h10);
      q_mode = 0; q_force = 1;
      clear_logs();
      tick(1);
      q_force = 0;
      run_results(1);
      chk("t3_cnt0_ignored", 32'(res_q[0]), 32'h10);
      clear_logs();
      wait_cnt(9);
      q_force = 1;
      tick(1);
      q_force = 0;
      run_results(1);
      chk("t3_qpulse", 32'(res_q[0]), 32'h08);
      q_mode = 1;

      clear_logs();
      wait_cnt(2);
      op_valid = 1; op_spike = 2'b01; op_time = {4'd0, 4'd12};
      tick(1);
      op_valid = 0;
      run_results(2);
      chk("t4_res0", 32'(res_q[0]), 32'h10);
      chk("t4_res1", 32'(res_q[1]), 32'h0C);
      chk("t4_trunc", 32'(snap_q[1][G-1:0]), 32'hE000);
      chk("t4_nowrap", 32'(pulse_out), 32'd0);

      clear_logs();
      wait_cnt(2);
      op_valid = 1; op_spike = 2'b11; op_time = {4'd1, 4'd0};
      tick(1);
      chk("t5_full", 32'(op_ready), 32'd0);
      op_spike = 2'b01; op_time = {4'd0, 4'd2};
      wait_cnt(15);
      chk("t5_stall", 32'(op_ready), 32'd0);
      tick(1);
      chk("t5_free", 32'(op_ready), 32'd1);
      tick(1);
      chk("t5_taken", 32'(op_ready), 32'd0);
      op_valid = 0;
      run_results(3);
      chk("t5_res0", 32'(res_q[0]), 32'h10);
      chk("t5_res1", 32'(res_q[1]), 32'h00);
      chk("t5_res2", 32'(res_q[2]), 32'h02);

      clear_logs();
      wait_cnt(15);
      chk("t5_bp_ready", 32'(op_ready), 32'd1);
      op_valid = 1; op_spike = 2'b10; op_time = {4'd7, 4'd0};
      tick(1);
      op_valid = 0;
      chk("t5_bypass_empty", 32'(op_ready), 32'd1);
      run_results(2);
      chk("t5_bypass_res", 32'(res_q[1]), 32'h07);
      chk("t5_bypass_pb", 32'(snap_q[1][2*G-1:G]), 32'hFF00);

      wait_cnt(5);
      en = 0;
      clear_logs();
      run_results(1);
      chk("t6_last_res", 32'(res_q[0]), 32'h10);
      chk("t6_idle_grst", 32'(grst), 32'd1);
      chk("t6_idle_gs", 32'(gamma_start), 32'd0);
      tick(20);
      chk("t6_idle_quiet", 32'(res_q.size()), 32'd1);
      en = 1;
      tick(1);
      wait_cnt(3);
      op_valid = 1; op_spike = 2'b11; op_time = {4'd3, 4'd3};
      tick(1);
      op_valid = 0;
      chk("t6_pend", 32'(op_ready), 32'd0);
      wait_cnt(7);
      rst = 1;
      tick(1);
      rst = 0; en = 0;
      clear_logs();
      chk("t6_rst_grst", 32'(grst), 32'd1);
      chk("t6_rst_rv", 32'(res_valid), 32'd0);
      tick(30);
      chk("t6_no_result", 32'(res_q.size()), 32'd0);
      chk("t6_slot_free", 32'(op_ready), 32'd1);
      en = 1;
      run_results(2);
      en = 0;
      chk("t6_after0", 32'(res_q[0]), 32'h10);
      chk("t6_after1", 32'(res_q[1]), 32'h10);
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
